// File: rtl/vec_pkg.sv
// Shared vector-datapath definitions.
// Holds the register width and register-address width that the ALU, the
// register file and the writeback stage must agree on. It also holds the
// retired-counter width and the writeback FSM state type.
package vec_pkg;

    localparam int DATA_W     = 512;  // one vector register / one ALU result half
    localparam int REG_ADDR_W = 3;    // 8 vector registers
    localparam int CNT_W      = 16;   // retired-instruction counter width

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CAPTURE  = 2'd1,
        WRITE_LO = 2'd2,
        WRITE_HI = 2'd3
    } wb_state_e;

endpackage

// File: rtl/vec_writeback.sv
// vec_writeback: vector writeback stage directly downstream of the vector ALU.
//
// An accepted issue is latched in IDLE. In CAPTURE the ALU result halves
// (A3 low, A4 high) are registered. The result is then written to the
// register file as one beat (add) or two beats (mul: lo -> rd, hi -> rd+1).
// While a result is pending, issue_ready is low so the ALU is not re-triggered.
//
// Ports
//   clk, reset        : single clock, synchronous active-high reset
//   issue_valid/_mul/_rd, issue_ready : issue side (ready only in IDLE)
//   A3, A4            : ALU result low/high half, valid in the CAPTURE cycle
//   wb_valid/wb_ready, wb_addr, wb_data : register-file write port
//   retired           : count of fully written-back instructions (wraps)
//   busy              : FSM not in IDLE
//   dbg_state         : current FSM state, for observation
//
// Handshake: a beat transfers on a cycle where wb_valid && wb_ready.
// Once wb_valid rises, wb_addr/wb_data are held until that transfer.
// wb_valid only falls after a transfer, or on reset.
// The wb_* outputs are decoded from registered state only; wb_ready steers
// only the next state.
module vec_writeback
    import vec_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  issue_valid,
    input  logic                  issue_mul,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    output logic                  issue_ready,
    input  logic [DATA_W-1:0]     A3,
    input  logic [DATA_W-1:0]     A4,
    output logic                  wb_valid,
    input  logic                  wb_ready,
    output logic [REG_ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0]     wb_data,
    output logic [CNT_W-1:0]      retired,
    output logic                  busy,
    output wb_state_e             dbg_state
);

    wb_state_e             r_state;
    wb_state_e             w_next_state;
    logic                  r_mul;
    logic [REG_ADDR_W-1:0] r_rd;
    logic [DATA_W-1:0]     r_lo_buf;
    logic [DATA_W-1:0]     r_hi_buf;  // for add this is just the carry-out, never written
    logic [CNT_W-1:0]      r_retired;
    logic                  w_accept;
    logic                  w_retire;
    logic [REG_ADDR_W-1:0] w_rd_hi;

    // Second mul beat targets rd+1; truncation makes register 7 wrap to 0.
    assign w_rd_hi = r_rd + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        issue_ready  = 1'b0;
        wb_valid     = 1'b0;
        wb_addr      = '0;
        wb_data      = '0;
        w_accept     = 1'b0;
        w_retire     = 1'b0;
        case (r_state)
            IDLE: begin
                issue_ready = 1'b1;
                if (issue_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = CAPTURE;
                end
            end
            CAPTURE: begin
                w_next_state = WRITE_LO;
            end
            WRITE_LO: begin
                wb_valid = 1'b1;
                wb_addr  = r_rd;
                wb_data  = r_lo_buf;
                if (wb_ready) begin
                    if (r_mul) begin
                        w_next_state = WRITE_HI;
                    end else begin
                        w_retire     = 1'b1;
                        w_next_state = IDLE;
                    end
                end
            end
            WRITE_HI: begin
                wb_valid = 1'b1;
                wb_addr  = w_rd_hi;
                wb_data  = r_hi_buf;
                if (wb_ready) begin
                    w_retire     = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mul     <= 1'b0;
            r_rd      <= '0;
            r_lo_buf  <= '0;
            r_hi_buf  <= '0;
            r_retired <= '0;
        end else begin
            if (w_accept) begin
                r_mul <= issue_mul;
                r_rd  <= issue_rd;
            end
            // The ALU result of the issue cycle is presented one cycle later.
            if (r_state == CAPTURE) begin
                r_lo_buf <= A3;
                r_hi_buf <= A4;
            end
            if (w_retire) begin
                r_retired <= r_retired + 1'b1;
            end
        end
    end

    assign retired   = r_retired;
    assign busy      = (r_state != IDLE);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_vec_writeback.sv
module tb_vec_writeback;
    import vec_pkg::*;

    logic                  clk;
    logic                  reset;
    logic                  issue_valid;
    logic                  issue_mul;
    logic [REG_ADDR_W-1:0] issue_rd;
    logic                  issue_ready;
    logic [DATA_W-1:0]     A3;
    logic [DATA_W-1:0]     A4;
    logic                  wb_valid;
    logic                  wb_ready;
    logic [REG_ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0]     wb_data;
    logic [CNT_W-1:0]      retired;
    logic                  busy;
    wb_state_e             dbg_state;

    vec_writeback dut (
        .clk         (clk),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_mul   (issue_mul),
        .issue_rd    (issue_rd),
        .issue_ready (issue_ready),
        .A3          (A3),
        .A4          (A4),
        .wb_valid    (wb_valid),
        .wb_ready    (wb_ready),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .retired     (retired),
        .busy        (busy),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1);
    end

    // ---------------- scoreboard ----------------
    logic [REG_ADDR_W+DATA_W-1:0] exp_q[$];
    int                           beats_seen = 0;
    logic [CNT_W-1:0]             exp_retired = '0;

    task automatic chk(input string name, input logic [527:0] act, input logic [527:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [REG_ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
        exp_q.push_back({addr, data});
    endtask

    logic                  prev_valid = 1'b0;
    logic                  prev_hs    = 1'b0;
    logic                  prev_reset = 1'b1;
    logic [REG_ADDR_W-1:0] prev_addr  = '0;
    logic [DATA_W-1:0]     prev_data  = '0;

    always @(negedge clk) begin
        logic [REG_ADDR_W+DATA_W-1:0] e;
        if (!reset && wb_valid && wb_ready) begin
            beats_seen++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_beat: got addr=%0d data=%0h expected no beat", wb_addr, wb_data);
            end else begin
                e = exp_q.pop_front();
                chk("wb_beat", {wb_addr, wb_data}, e);
            end
        end
        // A stalled beat must stay put until it transfers.
        if (prev_valid && !prev_hs && !prev_reset) begin
            chk("wb_hold", {wb_valid, wb_addr, wb_data}, {1'b1, prev_addr, prev_data});
        end
        prev_valid = wb_valid;
        prev_hs    = wb_valid && wb_ready;
        prev_reset = reset;
        prev_addr  = wb_addr;
        prev_data  = wb_data;
    end

    // ---------------- ALU model and driver ----------------
    function automatic logic [1023:0] alu(input logic mul, input logic [511:0] a, input logic [511:0] b);
        if (mul) return {512'b0, a} * {512'b0, b};
        return {511'b0, {1'b0, a} + {1'b0, b}};
    endfunction

    function automatic logic [DATA_W-1:0] junk();
        return {16{$urandom()}};
    endfunction

    // Called at posedge+1 in IDLE; returns at posedge+1 of cycle T+2.
    task automatic issue_op(input logic mul, input logic [2:0] rd, input logic [511:0] a, input logic [511:0] b);
        logic [1023:0] r;
        chk("issue_ready_idle", issue_ready, 1);
        issue_valid = 1'b1;
        issue_mul   = mul;
        issue_rd    = rd;
        A3 = junk();
        A4 = junk();
        @(posedge clk); #1;
        issue_valid = 1'b0;
        issue_mul   = 1'($urandom_range(0, 1));
        issue_rd    = 3'($urandom_range(0, 7));
        r  = alu(mul, a, b);
        A3 = r[511:0];
        A4 = r[1023:512];
        chk("capture_state", dbg_state, CAPTURE);
        chk("capture_no_valid", wb_valid, 0);
        chk("capture_not_ready", issue_ready, 0);
        @(posedge clk); #1;
        A3 = junk();
        A4 = junk();
        chk("first_valid_t2", wb_valid, 1);
    endtask

    task automatic wait_ready(input int exp_lat);
        int c;
        c = 0;
        while (!issue_ready && c < 20) begin
            @(posedge clk); #1;
            c++;
        end
        chk("ready_latency", c, exp_lat);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic         mul;
        logic [2:0]   rd;
        logic [511:0] a;
        logic [511:0] b;
        logic [2:0]   addr0;
        logic [511:0] d0;
        logic [2:0]   addr1;
        logic [511:0] d1;
    } vec_t;

    vec_t tbl[6];

    initial begin
        logic [511:0] ones;
        logic [511:0] top;
        logic [511:0] hi_sq;
        int           b0;

        ones  = {512{1'b1}};
        top   = {1'b1, 511'b0};
        hi_sq = {{511{1'b1}}, 1'b0};
        tbl[0] = '{1'b0, 3'd2, 512'd5, 512'd7, 3'd2, 512'd12, 3'd0, 512'd0};
        tbl[1] = '{1'b1, 3'd7, top, 512'd4, 3'd7, 512'd0, 3'd0, 512'd2};
        tbl[2] = '{1'b0, 3'd0, ones, 512'd1, 3'd0, 512'd0, 3'd0, 512'd0};
        tbl[3] = '{1'b1, 3'd3, 512'd3, 512'd5, 3'd3, 512'd15, 3'd4, 512'd0};
        tbl[4] = '{1'b1, 3'd5, ones, ones, 3'd5, 512'd1, 3'd6, hi_sq};
        tbl[5] = '{1'b0, 3'd6, 512'd100, 512'd23, 3'd6, 512'd123, 3'd0, 512'd0};

        reset       = 1'b1;
        issue_valid = 1'b0;
        issue_mul   = 1'b0;
        issue_rd    = '0;
        wb_ready    = 1'b0;
        A3          = '0;
        A4          = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        chk("rst_state", dbg_state, IDLE);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_addr", wb_addr, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_retired", retired, 0);
        chk("rst_busy", busy, 0);
        chk("rst_issue_ready", issue_ready, 1);

        // Table: wb_ready held high
        wb_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            push_exp(tbl[i].addr0, tbl[i].d0);
            if (tbl[i].mul) push_exp(tbl[i].addr1, tbl[i].d1);
            exp_retired = exp_retired + 1'b1;
            issue_op(tbl[i].mul, tbl[i].rd, tbl[i].a, tbl[i].b);
            wait_ready(tbl[i].mul ? 2 : 1);
            chk("tbl_retired", retired, exp_retired);
            chk("tbl_queue_empty", exp_q.size(), 0);
        end

        // Backpressure on both beats of a mul
        wb_ready = 1'b0;
        b0 = beats_seen;
        push_exp(3'd1, 512'd6);
        push_exp(3'd2, 512'd3);
        exp_retired = exp_retired + 1'b1;
        issue_op(1'b1, 3'd1, top + 512'd1, 512'd6);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("bp_lo_state", dbg_state, WRITE_LO);
            chk("bp_lo_not_ready", issue_ready, 0);
        end
        wb_ready = 1'b1;
        @(posedge clk); #1;
        wb_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("bp_hi_state", dbg_state, WRITE_HI);
            chk("bp_hi_addr", wb_addr, 2);
            chk("bp_hi_not_ready", issue_ready, 0);
        end
        wb_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_ready_after", issue_ready, 1);
        chk("bp_beats", beats_seen - b0, 2);
        chk("bp_retired", retired, exp_retired);

        // Issue while busy is ignored
        wb_ready = 1'b0;
        push_exp(3'd4, 512'd10);
        exp_retired = exp_retired + 1'b1;
        issue_op(1'b0, 3'd4, 512'd9, 512'd1);
        issue_valid = 1'b1;
        issue_mul   = 1'b1;
        issue_rd    = 3'd6;
        @(posedge clk); #1;
        issue_valid = 1'b0;
        chk("busy_state", dbg_state, WRITE_LO);
        chk("busy_addr", wb_addr, 4);
        wb_ready = 1'b1;
        @(posedge clk); #1;
        chk("busy_ready", issue_ready, 1);
        chk("busy_retired", retired, exp_retired);
        @(posedge clk); #1;
        chk("busy_no_extra", {busy, wb_valid}, 0);
        chk("busy_queue_empty", exp_q.size(), 0);

        // Reset during WRITE_HI, with a simultaneous issue that must be dropped
        push_exp(3'd6, 512'd0);
        push_exp(3'd7, 512'd2);
        issue_op(1'b1, 3'd6, top, 512'd4);
        @(posedge clk); #1;
        wb_ready = 1'b0;
        chk("rm_state_hi", dbg_state, WRITE_HI);
        chk("rm_lo_done", exp_q.size(), 1);
        reset       = 1'b1;
        issue_valid = 1'b1;
        issue_mul   = 1'b0;
        issue_rd    = 3'd1;
        @(posedge clk); #1;
        reset       = 1'b0;
        issue_valid = 1'b0;
        exp_q.delete();
        exp_retired = '0;
        chk("rm_state", dbg_state, IDLE);
        chk("rm_wb_valid", wb_valid, 0);
        chk("rm_wb_addr", wb_addr, 0);
        chk("rm_wb_data", wb_data, 0);
        chk("rm_retired", retired, 0);
        chk("rm_issue_ready", issue_ready, 1);
        wb_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk("rm_quiet", {busy, wb_valid}, 0);
        end

        // Counter wrap
        force dut.r_retired = 16'hFFFF;
        @(posedge clk); #1;
        release dut.r_retired;
        @(posedge clk); #1;
        chk("wrap_preload", retired, 16'hFFFF);
        exp_retired = 16'hFFFF;
        push_exp(3'd3, 512'd3);
        exp_retired = exp_retired + 1'b1;
        issue_op(1'b0, 3'd3, 512'd1, 512'd2);
        wait_ready(1);
        chk("wrap_retired", retired, exp_retired);
        chk("wrap_queue_empty", exp_q.size(), 0);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
